stim_pulse_sequencer: RTL and testbench
=======================================

# stim_pulse_sequencer

Synthesizable, clocked sequencer for the stimulator's biphasic pulse train. Each period it runs rest → cathodic → inter-pulse delay → anodic → discharge, with cycle-exact timing. It adds two optional behaviours: magnitude ramping (a triangle profile) and channel sweeping. It sits between the register/config layer and the analog stimulator front end, and drives that front end's phase enables, channel select and DAC magnitude code.

## Interface
- CNT_W, 16, width of all phase/period length fields (clock cycles)
- MAG_W, 5, magnitude code width (code = mA − 1)
- CH_W, 2, channel select width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  level; rising edge while IDLE starts a train, low requests stop
- ramp_en  in  1  1 = triangle magnitude ramp, 0 = fixed magnitude
- sweep_en  in  1  1 = step through channels, 0 = fixed channel
- period_len  in  CNT_W  total pulse period in cycles
- cat_len, ano_len, dis_len  in  CNT_W  phase lengths, each ≥ 1
- ipd_len  in  CNT_W  inter-pulse delay, 0 allowed (phase skipped)
- mag_target  in  MAG_W  fixed magnitude / ramp peak code T
- channel  in  CH_W  fixed channel when sweep_en = 0
- num_ch  in  CH_W+1  channels swept, 1..2^CH_W
- dwell  in  CNT_W  pulses per channel when sweeping without ramp, ≥ 1
- en_st  out  1  front-end enable, equals busy
- cat_st, ano_st, dis_st  out  1  phase enables, mutually exclusive
- ch_sel_st  out  CH_W  channel select
- mag_st  out  MAG_W  DAC magnitude code
- busy  out  1  state ≠ IDLE
- pulse_done  out  1  one-cycle strobe in the last DIS cycle of each pulse
- cfg_err  out  1  sticky; start rejected because of invalid config

## Operation
- States: IDLE, REST, CAT, IPD, ANO, DIS.
- Start: enable is sampled 0→1 while in IDLE.
  - All config inputs are latched. Config changes during a train are ignored.
  - Validation, with the sum computed at CNT_W+3 bits:
    - rest_len = period_len − (cat_len + ipd_len + ano_len + dis_len) must be ≥ 1;
    - cat_len, ano_len and dis_len must each be ≥ 1;
    - num_ch must be ≥ 1 and ≤ 2^CH_W when sweep_en = 1;
    - dwell must be ≥ 1 when sweep_en = 1 and ramp_en = 0.
  - If validation fails: cfg_err is set and the block stays in IDLE. cfg_err clears on the next accepted start or on reset.
- Phase sequence: REST (rest_len) → CAT (cat_len) → IPD (ipd_len; skipped if 0, CAT goes directly to ANO) → ANO (ano_len) → DIS (dis_len) → REST.
- Phase outputs: cat_st is high only in CAT, ano_st only in ANO, dis_st only in DIS. All are low in REST, IPD and IDLE.
- Magnitude and channel update only at the DIS→REST boundary, so they are constant for the whole of each pulse.
- Fixed mode (ramp_en = 0): mag_st = mag_target throughout.
- Ramp mode (ramp_en = 1):
  - Each ramp cycle is 2T+1 pulses with codes 0, 1, …, T, T−1, …, 0.
  - Cycles repeat back to back, so code 0 appears on two consecutive pulses at each cycle boundary.
  - T = 0 gives every pulse code 0.
- Sweep mode (sweep_en = 1):
  - ch_sel_st starts at 0.
  - It advances after each dwell: dwell pulses without ramp, or one full ramp cycle (2T+1 pulses) with ramp.
  - It wraps from num_ch−1 back to 0.
- Fixed channel (sweep_en = 0): ch_sel_st = channel latched at start.
- Stop, when enable goes low:
  - In REST: go to IDLE at the next edge.
  - In CAT, IPD, ANO or DIS: finish the pulse through DIS, then go to IDLE. A biphasic pulse is never truncated.
  - Re-raising enable before the block reaches IDLE does not cancel the stop.
- IDLE outputs: all phase enables 0. mag_st, ch_sel_st, en_st and busy are 0.

## Timing
- Reset (rst_n low at an edge): state = IDLE and every output = 0, including cfg_err. This applies immediately, mid-pulse included; abort is only through reset.
- Start latency: enable is sampled high at edge k (low at k−1) → REST begins at edge k+1, with busy = en_st = 1 from k+1.
- First cat_st assertion: edge k+1+rest_len.
- Every phase output is high for exactly its programmed number of cycles.
- Pulse-to-pulse spacing (cat_st rise to cat_st rise) = period_len cycles exactly.
- pulse_done is high for exactly one cycle, the last DIS cycle.
- Simultaneous events:
  - Stop arriving in the last DIS cycle: go to IDLE at the next edge.
  - Stop in the same cycle as a ramp or channel wrap: the update is discarded and IDLE values apply.

## Test plan
- Timing check. Config: period 50, cat 10, ipd 2, ano 10, dis 3, fixed mag 9, channel 2, start. Required: cat_st rises 26 cycles after start, phases last 10/2/10/3 cycles, period is 50, mag_st = 9, ch_sel_st = 2.
- Ramp profile. Config: ramp, T = 3. Required: mag_st codes on 14 consecutive pulses are 0,1,2,3,2,1,0,0,1,2,3,2,1,0.
- Sweep without ramp. Config: num_ch 3, dwell 2. Required: ch_sel_st over 8 pulses is 0,0,1,1,2,2,0,0.
- Sweep with ramp. Config: T = 2, num_ch 2. Required: 5 pulses on channel 0 (codes 0,1,2,1,0), then 5 on channel 1.
- Stop behaviour.
  - enable drops in mid-CAT → pulse completes through DIS, busy falls the cycle after the last DIS.
  - enable drops in REST → next cycle is IDLE with no CAT.
- Config error and reset.
  - period 20 with phase sum 20 → cfg_err = 1 and busy stays 0.
  - rst_n low mid-ANO → all outputs 0 at that edge.

Source files
------------

// File: rtl/stim_pulse_sequencer.sv
// Biphasic pulse-train sequencer: rest, cathodic, inter-pulse delay, anodic
// and discharge phases, with optional triangle magnitude ramp and channel sweep.

module stim_pulse_sequencer #(
    parameter int CNT_W = 16,
    parameter int MAG_W = 5,
    parameter int CH_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             ramp_en,
    input  logic             sweep_en,
    input  logic [CNT_W-1:0] period_len,
    input  logic [CNT_W-1:0] cat_len,
    input  logic [CNT_W-1:0] ipd_len,
    input  logic [CNT_W-1:0] ano_len,
    input  logic [CNT_W-1:0] dis_len,
    input  logic [MAG_W-1:0] mag_target,
    input  logic [CH_W-1:0]  channel,
    input  logic [CH_W:0]    num_ch,
    input  logic [CNT_W-1:0] dwell,
    output logic             en_st,
    output logic             cat_st,
    output logic             ano_st,
    output logic             dis_st,
    output logic [CH_W-1:0]  ch_sel_st,
    output logic [MAG_W-1:0] mag_st,
    output logic             busy,
    output logic             pulse_done,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REST,
        S_CAT,
        S_IPD,
        S_ANO,
        S_DIS
    } state_t;

    localparam int SUM_W = CNT_W + 3;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [MAG_W-1:0] MAG_ONE = MAG_W'(1);
    localparam logic [CH_W:0]    NCH_ONE = (CH_W+1)'(1);
    localparam logic [CH_W:0]    NCH_MAX = {1'b1, {CH_W{1'b0}}};

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             en_q1;
    logic             en_q2;
    logic             stop_req;
    logic             stop_nxt;

    logic [CNT_W-1:0] l_rest;
    logic [CNT_W-1:0] l_cat;
    logic [CNT_W-1:0] l_ipd;
    logic [CNT_W-1:0] l_ano;
    logic [CNT_W-1:0] l_dis;
    logic [CNT_W-1:0] l_dwell;
    logic [MAG_W-1:0] l_tgt;
    logic [CH_W:0]    l_num_ch;
    logic             l_ramp;
    logic             l_sweep;

    logic [MAG_W-1:0] mag;
    logic             up;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] dwell_cnt;

    logic [SUM_W-1:0] phase_sum;
    logic [CNT_W-1:0] rest_in;
    logic             cfg_ok;
    logic             start_pulse;
    logic             start_go;
    logic             start_bad;
    logic             pulse_end;
    logic             going_idle;

    logic [MAG_W-1:0] mag_adv;
    logic             up_adv;
    logic             ramp_wrap;
    logic             ch_step;
    logic [CH_W-1:0]  ch_adv;

    // Sum is kept wide so large phase lengths cannot wrap into a valid rest.
    always_comb begin
        phase_sum = SUM_W'(cat_len) + SUM_W'(ipd_len)
                  + SUM_W'(ano_len) + SUM_W'(dis_len);
        rest_in   = period_len - phase_sum[CNT_W-1:0];
        cfg_ok    = (SUM_W'(period_len) > phase_sum)
                  && (cat_len != '0)
                  && (ano_len != '0)
                  && (dis_len != '0)
                  && (!sweep_en
                      || ((num_ch != '0) && (num_ch <= NCH_MAX)))
                  && (!(sweep_en && !ramp_en) || (dwell != '0));
    end

    assign start_pulse = en_q1 & ~en_q2;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stop_nxt  = stop_req;
        start_go  = 1'b0;
        start_bad = 1'b0;
        pulse_end = 1'b0;
        unique case (state)
            S_IDLE: begin
                stop_nxt = 1'b0;
                if (start_pulse) begin
                    if (cfg_ok) begin
                        state_nxt = S_REST;
                        cnt_nxt   = rest_in - CNT_ONE;
                        start_go  = 1'b1;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            S_REST: begin
                stop_nxt = 1'b0;
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = S_CAT;
                    cnt_nxt   = l_cat - CNT_ONE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_CAT: begin
                stop_nxt = stop_req | ~enable;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (l_ipd == '0) begin
                    state_nxt = S_ANO;
                    cnt_nxt   = l_ano - CNT_ONE;
                end else begin
                    state_nxt = S_IPD;
                    cnt_nxt   = l_ipd - CNT_ONE;
                end
            end
            S_IPD: begin
                stop_nxt = stop_req | ~enable;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    state_nxt = S_ANO;
                    cnt_nxt   = l_ano - CNT_ONE;
                end
            end
            S_ANO: begin
                stop_nxt = stop_req | ~enable;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    state_nxt = S_DIS;
                    cnt_nxt   = l_dis - CNT_ONE;
                end
            end
            S_DIS: begin
                if (cnt != '0) begin
                    stop_nxt = stop_req | ~enable;
                    cnt_nxt  = cnt - CNT_ONE;
                end else begin
                    pulse_end = 1'b1;
                    stop_nxt  = 1'b0;
                    if (stop_req || !enable) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_REST;
                        cnt_nxt   = l_rest - CNT_ONE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                stop_nxt  = 1'b0;
            end
        endcase
    end

    assign going_idle = (state != S_IDLE) && (state_nxt == S_IDLE);

    // Triangle walk; a wrap marks the end of one 2T+1 pulse ramp cycle.
    always_comb begin
        mag_adv   = mag;
        up_adv    = up;
        ramp_wrap = 1'b0;
        if (up) begin
            if (mag != l_tgt) begin
                mag_adv = mag + MAG_ONE;
            end else if (l_tgt == '0) begin
                ramp_wrap = 1'b1;
            end else begin
                up_adv  = 1'b0;
                mag_adv = mag - MAG_ONE;
            end
        end else if (mag == '0) begin
            ramp_wrap = 1'b1;
            up_adv    = 1'b1;
        end else begin
            mag_adv = mag - MAG_ONE;
        end
    end

    always_comb begin
        ch_step = l_ramp ? ramp_wrap : (dwell_cnt == l_dwell - CNT_ONE);
        if ({1'b0, ch} == l_num_ch - NCH_ONE) begin
            ch_adv = '0;
        end else begin
            ch_adv = ch + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            en_q1     <= 1'b0;
            en_q2     <= 1'b0;
            stop_req  <= 1'b0;
            cfg_err   <= 1'b0;
            l_rest    <= '0;
            l_cat     <= '0;
            l_ipd     <= '0;
            l_ano     <= '0;
            l_dis     <= '0;
            l_dwell   <= '0;
            l_tgt     <= '0;
            l_num_ch  <= '0;
            l_ramp    <= 1'b0;
            l_sweep   <= 1'b0;
            mag       <= '0;
            up        <= 1'b1;
            ch        <= '0;
            dwell_cnt <= '0;
        end else begin
            en_q1    <= enable;
            en_q2    <= en_q1;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            stop_req <= stop_nxt;
            if (start_bad) begin
                cfg_err <= 1'b1;
            end
            if (start_go) begin
                cfg_err   <= 1'b0;
                l_rest    <= rest_in;
                l_cat     <= cat_len;
                l_ipd     <= ipd_len;
                l_ano     <= ano_len;
                l_dis     <= dis_len;
                l_dwell   <= dwell;
                l_tgt     <= mag_target;
                l_num_ch  <= num_ch;
                l_ramp    <= ramp_en;
                l_sweep   <= sweep_en;
                mag       <= ramp_en ? '0 : mag_target;
                up        <= 1'b1;
                ch        <= sweep_en ? '0 : channel;
                dwell_cnt <= '0;
            end else if (going_idle) begin
                mag       <= '0;
                up        <= 1'b1;
                ch        <= '0;
                dwell_cnt <= '0;
            end else if (pulse_end) begin
                if (l_ramp) begin
                    mag <= mag_adv;
                    up  <= up_adv;
                end
                if (l_sweep && ch_step) begin
                    ch <= ch_adv;
                end
                dwell_cnt <= ch_step ? '0 : dwell_cnt + CNT_ONE;
            end
        end
    end

    assign busy       = (state != S_IDLE);
    assign en_st      = busy;
    assign cat_st     = (state == S_CAT);
    assign ano_st     = (state == S_ANO);
    assign dis_st     = (state == S_DIS);
    assign pulse_done = (state == S_DIS) && (cnt == '0);
    assign mag_st     = busy ? mag : '0;
    assign ch_sel_st  = busy ? ch : '0;

endmodule

// File: tb/tb_stim_pulse_sequencer.sv
// Bench for stim_pulse_sequencer: directed scenarios plus randomized trains
// checked against an arithmetic model of pulse timing, ramp and sweep.

module tb_stim_pulse_sequencer;

    localparam int CNT_W = 16;
    localparam int MAG_W = 5;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             ramp_en = 1'b0;
    logic             sweep_en = 1'b0;
    logic [CNT_W-1:0] period_len = '0;
    logic [CNT_W-1:0] cat_len = '0;
    logic [CNT_W-1:0] ipd_len = '0;
    logic [CNT_W-1:0] ano_len = '0;
    logic [CNT_W-1:0] dis_len = '0;
    logic [MAG_W-1:0] mag_target = '0;
    logic [CH_W-1:0]  channel = '0;
    logic [CH_W:0]    num_ch = '0;
    logic [CNT_W-1:0] dwell = '0;
    logic             en_st;
    logic             cat_st;
    logic             ano_st;
    logic             dis_st;
    logic [CH_W-1:0]  ch_sel_st;
    logic [MAG_W-1:0] mag_st;
    logic             busy;
    logic             pulse_done;
    logic             cfg_err;

    stim_pulse_sequencer #(
        .CNT_W(CNT_W),
        .MAG_W(MAG_W),
        .CH_W (CH_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .ramp_en   (ramp_en),
        .sweep_en  (sweep_en),
        .period_len(period_len),
        .cat_len   (cat_len),
        .ipd_len   (ipd_len),
        .ano_len   (ano_len),
        .dis_len   (dis_len),
        .mag_target(mag_target),
        .channel   (channel),
        .num_ch    (num_ch),
        .dwell     (dwell),
        .en_st     (en_st),
        .cat_st    (cat_st),
        .ano_st    (ano_st),
        .dis_st    (dis_st),
        .ch_sel_st (ch_sel_st),
        .mag_st    (mag_st),
        .busy      (busy),
        .pulse_done(pulse_done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    int rise_t[64];
    int catw[64];
    int ipdw[64];
    int anow[64];
    int disw[64];
    int magv[64];
    int chv[64];
    int done_t[64];
    int dis_last[64];
    int dcnt[64];
    int npul;
    int busy_t;
    int excl_err;
    int const_err;
    int enb_err;
    int timed_out;
    int t_en;

    function automatic logic [13:0] all_outs();
        return {en_st, cat_st, ano_st, dis_st, busy, pulse_done,
                cfg_err, ch_sel_st, mag_st};
    endfunction

    function automatic int exp_mag(input int n);
        int t;
        int p;
        t = int'(mag_target);
        if (!ramp_en) return t;
        p = n % (2 * t + 1);
        return (p <= t) ? p : 2 * t - p;
    endfunction

    function automatic int exp_ch(input int n);
        int blk;
        if (!sweep_en) return int'(channel);
        blk = ramp_en ? 2 * int'(mag_target) + 1 : int'(dwell);
        return (n / blk) % int'(num_ch);
    endfunction

    task automatic set_cfg(input int per, input int c, input int i,
                           input int a, input int d, input int tgt,
                           input int ch, input int nch, input int dw,
                           input bit rmp, input bit swp);
        period_len = CNT_W'(per);
        cat_len    = CNT_W'(c);
        ipd_len    = CNT_W'(i);
        ano_len    = CNT_W'(a);
        dis_len    = CNT_W'(d);
        mag_target = MAG_W'(tgt);
        channel    = CH_W'(ch);
        num_ch     = (CH_W+1)'(nch);
        dwell      = CNT_W'(dw);
        ramp_en    = rmp;
        sweep_en   = swp;
    endtask

    task automatic start_train();
        @(negedge clk);
        enable = 1'b1;
        t_en = cyc;
    endtask

    task automatic stop_idle(input string name);
        int ok;
        enable = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        vectors++;
        if (ok != 1) begin
            miscompares++;
            $display("FAIL %s_stop: busy=%0d required 0", name, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic capture(input int target, input int budget);
        bit prev_cat;
        bit prev_dis;
        bit inp;
        int p;
        prev_cat = 1'b0;
        prev_dis = 1'b0;
        inp = 1'b0;
        p = -1;
        for (int k = 0; k < 64; k++) begin
            rise_t[k] = 0; catw[k] = 0; ipdw[k] = 0; anow[k] = 0;
            disw[k] = 0; magv[k] = -1; chv[k] = -1; done_t[k] = -1;
            dis_last[k] = -2; dcnt[k] = 0;
        end
        npul = 0; busy_t = -1; excl_err = 0; const_err = 0;
        enb_err = 0; timed_out = 1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busy && busy_t < 0) busy_t = cyc;
            if (en_st !== busy) enb_err++;
            if (int'(cat_st) + int'(ano_st) + int'(dis_st) > 1) excl_err++;
            if (inp && prev_dis && !dis_st) begin
                inp = 1'b0;
                if (p + 1 == target) begin
                    timed_out = 0;
                    break;
                end
            end
            if (cat_st && !prev_cat && p < 63) begin
                p++;
                inp = 1'b1;
                rise_t[p] = cyc;
                magv[p] = int'(mag_st);
                chv[p] = int'(ch_sel_st);
            end
            if (inp) begin
                if (cat_st) catw[p]++;
                if (ano_st) anow[p]++;
                if (dis_st) begin
                    disw[p]++;
                    dis_last[p] = cyc;
                end
                if (!cat_st && !ano_st && !dis_st) ipdw[p]++;
                if (int'(mag_st) != magv[p] || int'(ch_sel_st) != chv[p])
                    const_err++;
                if (pulse_done) begin
                    dcnt[p]++;
                    done_t[p] = cyc;
                end
            end
            prev_cat = cat_st;
            prev_dis = dis_st;
        end
        npul = p + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_outs: got %b required 0", all_outs());
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%0d required 0", busy);
        end
    endtask

    task automatic test_timing();
        set_cfg(50, 10, 2, 10, 3, 9, 2, 1, 1, 0, 0);
        start_train();
        capture(3, 400);
        vectors++;
        if (timed_out != 0 || busy_t != t_en + 2) begin
            miscompares++;
            $display("FAIL timing_start: busy at %0d required %0d (to=%0d)",
                     busy_t - t_en, 2, timed_out);
        end
        vectors++;
        if (rise_t[0] - t_en - 1 != 26) begin
            miscompares++;
            $display("FAIL timing_first_cat: got %0d required 26",
                     rise_t[0] - t_en - 1);
        end
        for (int p = 0; p < 3; p++) begin
            vectors++;
            if (catw[p] != 10 || ipdw[p] != 2 || anow[p] != 10
                || disw[p] != 3) begin
                miscompares++;
                $display("FAIL timing_phases[%0d]: got %0d/%0d/%0d/%0d required 10/2/10/3",
                         p, catw[p], ipdw[p], anow[p], disw[p]);
            end
            vectors++;
            if (magv[p] != 9 || chv[p] != 2) begin
                miscompares++;
                $display("FAIL timing_magch[%0d]: got %0d/%0d required 9/2",
                         p, magv[p], chv[p]);
            end
            if (p > 0) begin
                vectors++;
                if (rise_t[p] - rise_t[p-1] != 50) begin
                    miscompares++;
                    $display("FAIL timing_period[%0d]: got %0d required 50",
                             p, rise_t[p] - rise_t[p-1]);
                end
            end
        end
        stop_idle("timing");
    endtask

    task automatic test_ramp();
        int exp_seq[14] = '{0, 1, 2, 3, 2, 1, 0, 0, 1, 2, 3, 2, 1, 0};
        set_cfg(6, 1, 0, 2, 1, 3, 1, 1, 1, 1, 0);
        start_train();
        capture(14, 200);
        vectors++;
        if (timed_out != 0) begin
            miscompares++;
            $display("FAIL ramp_timeout: pulses %0d required 14", npul);
        end
        for (int p = 0; p < 14; p++) begin
            vectors++;
            if (magv[p] != exp_seq[p] || ipdw[p] != 0) begin
                miscompares++;
                $display("FAIL ramp_mag[%0d]: got %0d ipd %0d required %0d ipd 0",
                         p, magv[p], ipdw[p], exp_seq[p]);
            end
        end
        stop_idle("ramp");
    endtask

    task automatic test_sweep();
        int exp_seq[8] = '{0, 0, 1, 1, 2, 2, 0, 0};
        set_cfg(7, 1, 1, 1, 1, 12, 3, 3, 2, 0, 1);
        start_train();
        capture(8, 200);
        for (int p = 0; p < 8; p++) begin
            vectors++;
            if (chv[p] != exp_seq[p] || magv[p] != 12) begin
                miscompares++;
                $display("FAIL sweep_ch[%0d]: got ch %0d mag %0d required ch %0d mag 12",
                         p, chv[p], magv[p], exp_seq[p]);
            end
        end
        stop_idle("sweep");
    endtask

    task automatic test_sweep_ramp();
        int exp_m[5] = '{0, 1, 2, 1, 0};
        set_cfg(5, 1, 0, 1, 1, 2, 0, 2, 1, 1, 1);
        start_train();
        capture(10, 200);
        for (int p = 0; p < 10; p++) begin
            vectors++;
            if (magv[p] != exp_m[p % 5] || chv[p] != p / 5) begin
                miscompares++;
                $display("FAIL sweep_ramp[%0d]: got %0d/%0d required %0d/%0d",
                         p, magv[p], chv[p], exp_m[p % 5], p / 5);
            end
        end
        stop_idle("sweep_ramp");
    endtask

    task automatic test_random();
        int c, i, a, d, r, per, n;
        bit rmp, swp;
        for (int it = 0; it < 8; it++) begin
            c = $urandom_range(1, 6); i = $urandom_range(0, 3);
            a = $urandom_range(1, 6); d = $urandom_range(1, 6);
            r = $urandom_range(1, 6); per = c + i + a + d + r;
            rmp = 1'($urandom_range(0, 1));
            swp = 1'($urandom_range(0, 1));
            set_cfg(per, c, i, a, d,
                    rmp ? $urandom_range(0, 4) : $urandom_range(0, 31),
                    $urandom_range(0, 3), $urandom_range(1, 4),
                    $urandom_range(1, 3), rmp, swp);
            n = $urandom_range(4, 20);
            start_train();
            capture(n, (n + 2) * per + 20);
            vectors++;
            if (timed_out != 0 || busy_t != t_en + 2
                || rise_t[0] != t_en + 2 + r) begin
                miscompares++;
                $display("FAIL rand%0d_start: to=%0d busy %0d cat %0d required busy %0d cat %0d",
                         it, timed_out, busy_t, rise_t[0], t_en + 2, t_en + 2 + r);
            end
            for (int p = 0; p < n; p++) begin
                vectors++;
                if (catw[p] != c || ipdw[p] != i || anow[p] != a
                    || disw[p] != d) begin
                    miscompares++;
                    $display("FAIL rand%0d_phases[%0d]: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                             it, p, catw[p], ipdw[p], anow[p], disw[p], c, i, a, d);
                end
                vectors++;
                if (magv[p] != exp_mag(p) || chv[p] != exp_ch(p)) begin
                    miscompares++;
                    $display("FAIL rand%0d_magch[%0d]: got %0d/%0d required %0d/%0d",
                             it, p, magv[p], chv[p], exp_mag(p), exp_ch(p));
                end
                vectors++;
                if (dcnt[p] != 1 || done_t[p] != dis_last[p]
                    || (p > 0 && rise_t[p] - rise_t[p-1] != per)) begin
                    miscompares++;
                    $display("FAIL rand%0d_done[%0d]: strobes %0d at %0d last dis %0d",
                             it, p, dcnt[p], done_t[p], dis_last[p]);
                end
            end
            vectors++;
            if (excl_err != 0 || const_err != 0 || enb_err != 0) begin
                miscompares++;
                $display("FAIL rand%0d_invariants: excl %0d const %0d en %0d required 0",
                         it, excl_err, const_err, enb_err);
            end
            stop_idle("rand");
        end
    endtask

    task automatic test_stop_mid_cat();
        int ok, anw, dsw, lastd, idle_t, cat_after, reraised, seen;
        set_cfg(20, 5, 2, 4, 3, 7, 1, 1, 1, 0, 0);
        start_train();
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (cat_st) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        enable = 1'b0;
        anw = 0; dsw = 0; lastd = -1; idle_t = -1;
        cat_after = 0; reraised = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy) begin
                idle_t = cyc;
                break;
            end
            if (ano_st) anw++;
            if (dis_st) begin
                dsw++;
                lastd = cyc;
            end
            if (cat_st && anw > 0) cat_after++;
            if (ano_st && reraised == 0) begin
                enable = 1'b1;
                reraised = 1;
            end
        end
        vectors++;
        if (ok != 1 || anw != 4 || dsw != 3 || idle_t != lastd + 1
            || cat_after != 0) begin
            miscompares++;
            $display("FAIL stop_mid_cat: ano %0d dis %0d idle@%0d lastdis %0d required 4 3 lastdis+1",
                     anw, dsw, idle_t, lastd);
        end
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL stop_no_restart: busy cycles %0d required 0", seen);
        end
        stop_idle("stop_mid_cat");
    endtask

    task automatic test_stop_last_dis();
        int ok;
        set_cfg(12, 2, 0, 2, 2, 0, 0, 2, 1, 1, 1);
        start_train();
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pulse_done) begin
                ok = 1;
                break;
            end
        end
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (ok != 1 || all_outs() !== '0) begin
            miscompares++;
            $display("FAIL stop_last_dis: outs %b required 0 (seen %0d)",
                     all_outs(), ok);
        end
        repeat (2) @(negedge clk);
        start_train();
        capture(1, 60);
        vectors++;
        if (timed_out != 0 || magv[0] != 0 || chv[0] != 0) begin
            miscompares++;
            $display("FAIL stop_wrap_restart: mag %0d ch %0d required 0/0",
                     magv[0], chv[0]);
        end
        stop_idle("stop_last_dis");
    endtask

    task automatic test_stop_rest();
        int ok, cats;
        set_cfg(60, 2, 1, 2, 2, 5, 3, 1, 1, 0, 0);
        start_train();
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (ok != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_rest: busy %0d required 0 (started %0d)", busy, ok);
        end
        cats = 0;
        repeat (60) begin
            @(negedge clk);
            if (cat_st || busy) cats++;
        end
        vectors++;
        if (cats != 0) begin
            miscompares++;
            $display("FAIL stop_rest_quiet: active cycles %0d required 0", cats);
        end
    endtask

    task automatic test_cfg_err();
        int seen;
        set_cfg(20, 5, 5, 5, 5, 3, 0, 1, 1, 0, 0);
        start_train();
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy) seen++;
        end
        vectors++;
        if (cfg_err !== 1'b1 || seen != 0) begin
            miscompares++;
            $display("FAIL cfg_sum: err %0d busy cycles %0d required 1/0", cfg_err, seen);
        end
        stop_idle("cfg_a");
        set_cfg(21, 5, 5, 5, 5, 3, 0, 1, 1, 0, 0);
        start_train();
        capture(1, 80);
        vectors++;
        if (timed_out != 0 || cfg_err !== 1'b0 || rise_t[0] != t_en + 3) begin
            miscompares++;
            $display("FAIL cfg_rest1: err %0d cat@%0d required 0 @%0d",
                     cfg_err, rise_t[0] - t_en, 3);
        end
        stop_idle("cfg_b");
        set_cfg(65535, 65535, 65535, 65535, 65535, 3, 0, 1, 1, 0, 0);
        start_train();
        repeat (6) @(negedge clk);
        vectors++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_overflow: err %0d busy %0d required 1/0", cfg_err, busy);
        end
        stop_idle("cfg_c");
        set_cfg(12, 2, 1, 2, 2, 3, 0, 4, 1, 0, 1);
        start_train();
        repeat (4) @(negedge clk);
        vectors++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_nch4: err %0d busy %0d required 0/1", cfg_err, busy);
        end
        stop_idle("cfg_d");
        set_cfg(12, 2, 1, 2, 2, 3, 0, 5, 1, 0, 1);
        start_train();
        repeat (6) @(negedge clk);
        vectors++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_nch5: err %0d busy %0d required 1/0", cfg_err, busy);
        end
        stop_idle("cfg_e");
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL cfg_reset: outs %b required 0", all_outs());
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_ano();
        int ok;
        set_cfg(30, 4, 2, 6, 3, 17, 3, 1, 1, 0, 0);
        start_train();
        ok = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (ano_st) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (ok != 1 || all_outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_ano: outs %b required 0 (ano seen %0d)",
                     all_outs(), ok);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stays_idle: busy %0d required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_ramp();
        test_sweep();
        test_sweep_ramp();
        test_random();
        test_stop_mid_cat();
        test_stop_last_dis();
        test_stop_rest();
        test_cfg_err();
        test_reset_mid_ano();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
